recip_round_pack: RTL and testbench
===================================

RECIP_ROUND_PACK -- requirements
Module: recip_round_pack

Interface
REQ-001 SHALL have parameter: sig_width, 23, fraction bits of the IEEE format.
REQ-002 SHALL have parameter: exp_width, 8, exponent bits; bias = 2^(exp_width-1)-1.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  upstream operand and quotient valid.
REQ-006 SHALL have port: in_ready  output  1  block accepts the input this cycle.
REQ-007 SHALL have ports: sign_in  input  1  operand sign; exp_in  input  exp_width  operand biased exponent.
REQ-008 SHALL have port: frac_in  input  sig_width  operand fraction, used only for special-case detection.
REQ-009 SHALL have port: quotient  input  sig_width+1  reciprocal significand, MSB weight 2^0, value in (0.5,1].
REQ-010 SHALL have ports: guard_bit, round_bit, sticky_bit  input  1 each  bits below quotient LSB.
REQ-011 SHALL have port: out_valid  output  1  result valid.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port: result  output  1+exp_width+sig_width  packed IEEE reciprocal {sign, exp, frac}.
REQ-014 SHALL have ports: flag_inexact, flag_underflow, flag_divzero  output  1 each  valid with result.

Function
REQ-015 SHALL implement a 2-stage elastic pipeline: S1 normalizes, rounds, and classifies; S2 packs, exponent-adjusts, and holds the output.
REQ-016 Transfer SHALL occur on in_valid&in_ready at the input and on out_valid&out_ready at the output.
REQ-017 in_ready SHALL equal ~s1_valid | ~s2_valid | out_ready, and S1 SHALL advance into S2 whenever S2 is empty or draining.
REQ-018 Latency SHALL be 2 cycles from input acceptance to out_valid; throughput SHALL be 1 result/cycle while out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, result and flags SHALL hold stable, and no accepted item SHALL be dropped or reordered.
REQ-020 Normalization case A, quotient MSB=1 (Q=1.0): mantissa = quotient, G = guard, S = round|sticky, E = 2*bias - exp_in.
REQ-021 Normalization case B, quotient MSB=0: mantissa = {quotient[sig_width-1:0], guard}, G = round, S = sticky, E = 2*bias - exp_in - 1.
REQ-022 Rounding SHALL be round-to-nearest-even: increment when G & (L | S), where L is the mantissa LSB.
REQ-023 A rounding carry-out SHALL set the mantissa to 1.0 and increment E.
REQ-024 flag_inexact SHALL equal G|S for normal results.
REQ-025 E SHALL be computed signed, exp_width+2 bits wide.
REQ-026 When E <= 0, result SHALL be {sign_in, 0...0} (flush to zero) with flag_underflow=1 and flag_inexact=1.
REQ-027 An operand with exp_in=0 (zero or subnormal) SHALL produce {sign_in, all-ones exp, 0 frac} with flag_divzero=1; quotient SHALL be ignored.
REQ-028 An operand with exp_in all ones and frac_in=0 (infinity) SHALL produce {sign_in, 0...0}, all flags 0.
REQ-029 An operand with exp_in all ones and frac_in!=0 (NaN) SHALL produce canonical qNaN {0, all-ones exp, 1, 0...0}, all flags 0.
REQ-030 Special-case priority SHALL be NaN > Inf > zero > normal.
REQ-031 Otherwise result SHALL be {sign_in, E[exp_width-1:0], mantissa[sig_width-1:0]}.

Reset
REQ-032 While reset=1: s1_valid=0, s2_valid=0, out_valid=0, result=0, all flags=0, and in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight items, with no output transfer on the following cycles.
REQ-034 After reset deasserts, the first accepted input SHALL appear at the output 2 cycles later.

Verification (sig_width=23, exp_width=8)
REQ-035 exp_in=127, quotient=0x800000, g/r/s=0 -> result=0x3F800000 two cycles later, all flags 0.
REQ-036 exp_in=127, quotient=0x555555, g=0, r=1, s=1 (d=1.5) -> result=0x3F2AAAAB, flag_inexact=1; exp_in=128, quotient=0x800000 -> 0x3F000000.
REQ-037 exp_in=254, quotient=0x800000 -> result=0x00000000, flag_underflow=1, flag_inexact=1; exp_in=253, same quotient -> 0x00800000, no flags.
REQ-038 sign=1, exp_in=0 -> 0xFF800000 with flag_divzero=1; sign=1, exp_in=255, frac=0 -> 0x80000000; exp_in=255, frac=1 -> 0x7FC00000.
REQ-039 Offer 4 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, output holds first result; raise out_ready -> all 4 results in order, one per cycle, none lost.
REQ-040 Assert reset for 1 cycle with both stages full -> out_valid=0 immediately, in_ready=1; a new input afterwards -> out_valid exactly 2 cycles later.

Source files
------------

// File: rtl/recip_round_pack.sv
// -----------------------------------------------------------------------------
// recip_round_pack
//   Final stage of an IEEE-754 reciprocal unit. Takes the raw reciprocal
//   significand from the iterative divider, normalizes and rounds it
//   (round-to-nearest-even), resolves special operands, and packs the result.
//   Two-stage elastic pipeline with valid/ready handshakes on both sides:
//     S1: normalize, round, classify
//     S2: exponent adjust, pack, hold output until downstream accepts
//
// Parameters
//   sig_width  fraction bits of the IEEE format
//   exp_width  exponent bits (bias = 2^(exp_width-1)-1)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   sign_in, exp_in, frac_in    original operand fields (frac only for NaN/Inf)
//   quotient                    reciprocal significand, MSB weight 2^0, (0.5,1]
//   guard_bit, round_bit,
//   sticky_bit                  bits below the quotient LSB
//   out_valid / out_ready       downstream handshake
//   result                      packed {sign, exp, frac}
//   flag_inexact, flag_underflow,
//   flag_divzero                exception flags, valid with result
// -----------------------------------------------------------------------------
module recip_round_pack #(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           sign_in,
    input  logic [exp_width-1:0]           exp_in,
    input  logic [sig_width-1:0]           frac_in,
    input  logic [sig_width:0]             quotient,
    input  logic                           guard_bit,
    input  logic                           round_bit,
    input  logic                           sticky_bit,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [exp_width+sig_width:0]   result,
    output logic                           flag_inexact,
    output logic                           flag_underflow,
    output logic                           flag_divzero
);

    // Exponent arithmetic carries two extra bits: one for sign, one headroom.
    localparam int ew2 = exp_width + 2;
    localparam logic signed [ew2-1:0] two_bias = ew2'((2 ** exp_width) - 2);

    // ---------------------------------------------------------------- handshake
    logic s1_valid, s2_valid;
    logic advance;   // S2 is empty or draining this cycle, so S1 may move up
    logic take;

    assign advance   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | advance;
    assign take      = in_valid & in_ready;
    assign out_valid = s2_valid;

    // ------------------------------------------------ S1 combinational datapath
    logic                  case_b;    // quotient < 1.0, shift left by one
    logic [sig_width:0]    mant;
    logic                  g, s;
    logic                  round_up;
    logic [sig_width+1:0]  mant_sum;
    logic signed [ew2-1:0] e_pre;
    logic                  is_nan, is_inf, is_zero;

    // NOTE: every always_comb output gets a value on every path (here, by
    // assigning defaults first) so no latch is inferred.
    always_comb begin
        case_b = ~quotient[sig_width];
        mant   = quotient;
        g      = guard_bit;
        s      = round_bit | sticky_bit;
        if (case_b) begin
            mant = {quotient[sig_width-1:0], guard_bit};
            g    = round_bit;
            s    = sticky_bit;
        end
    end

    assign round_up = g & (mant[0] | s);
    assign mant_sum = {1'b0, mant} + {{(sig_width+1){1'b0}}, round_up};
    assign e_pre    = two_bias - $signed({2'b00, exp_in})
                               - $signed({{(ew2-1){1'b0}}, case_b});

    assign is_nan  = (&exp_in) & (|frac_in);
    assign is_inf  = (&exp_in) & ~(|frac_in);
    assign is_zero = ~(|exp_in);

    // --------------------------------------------------------------- S1 state
    logic                  s1_sign, s1_nan, s1_inf, s1_zero;
    logic                  s1_carry, s1_inexact;
    logic signed [ew2-1:0] s1_exp;
    logic [sig_width-1:0]  s1_frac;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_carry   <= 1'b0;
            s1_inexact <= 1'b0;
            s1_exp     <= '0;
            s1_frac    <= '0;
        end else if (take) begin
            s1_valid   <= 1'b1;
            s1_sign    <= sign_in;
            s1_nan     <= is_nan;
            s1_inf     <= is_inf;
            s1_zero    <= is_zero;
            // A carry out of the mantissa leaves the low bits all zero,
            // i.e. the mantissa is already 1.0; only the exponent moves.
            s1_carry   <= mant_sum[sig_width+1];
            s1_inexact <= g | s;
            s1_exp     <= e_pre;
            s1_frac    <= mant_sum[sig_width-1:0];
        end else if (advance) begin
            s1_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------ S2 combinational packing
    logic signed [ew2-1:0]        e_fin;
    logic [exp_width+sig_width:0] pack;
    logic                         pk_inexact, pk_underflow, pk_divzero;

    assign e_fin = s1_exp + $signed({{(ew2-1){1'b0}}, s1_carry});

    // Priority: NaN > Inf > zero > normal (with underflow flush).
    always_comb begin
        pack         = {s1_sign, e_fin[exp_width-1:0], s1_frac};
        pk_inexact   = s1_inexact;
        pk_underflow = 1'b0;
        pk_divzero   = 1'b0;
        if (s1_nan) begin
            pack       = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
            pk_inexact = 1'b0;
        end else if (s1_inf) begin
            pack       = {s1_sign, {(exp_width+sig_width){1'b0}}};
            pk_inexact = 1'b0;
        end else if (s1_zero) begin
            pack       = {s1_sign, {exp_width{1'b1}}, {sig_width{1'b0}}};
            pk_inexact = 1'b0;
            pk_divzero = 1'b1;
        end else if (e_fin <= 0) begin
            pack         = {s1_sign, {(exp_width+sig_width){1'b0}}};
            pk_inexact   = 1'b1;
            pk_underflow = 1'b1;
        end
    end

    // --------------------------------------------------------------- S2 state
    // NOTE: the output data registers are reset as well, because the result
    // and flags must read zero while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid       <= 1'b0;
            result         <= '0;
            flag_inexact   <= 1'b0;
            flag_underflow <= 1'b0;
            flag_divzero   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result         <= pack;
                flag_inexact   <= pk_inexact;
                flag_underflow <= pk_underflow;
                flag_divzero   <= pk_divzero;
            end
        end
    end

endmodule

// File: tb/tb_recip_round_pack.sv
// -----------------------------------------------------------------------------
// tb_recip_round_pack
//   Self-checking bench for recip_round_pack (sig_width=23, exp_width=8).
//   Expected words {result, inexact, underflow, divzero} are queued when an
//   input is accepted and compared in order when an output transfers.
// -----------------------------------------------------------------------------
module tb_recip_round_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic [23:0] quotient;
    logic        guard_bit, round_bit, sticky_bit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_inexact, flag_underflow, flag_divzero;

    recip_round_pack #(.sig_width(23), .exp_width(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign_in        (sign_in),
        .exp_in         (exp_in),
        .frac_in        (frac_in),
        .quotient       (quotient),
        .guard_bit      (guard_bit),
        .round_bit      (round_bit),
        .sticky_bit     (sticky_bit),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_inexact   (flag_inexact),
        .flag_underflow (flag_underflow),
        .flag_divzero   (flag_divzero)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    logic [34:0] sb[$];
    logic [34:0] cur_exp;
    logic        rand_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: treat {quotient,g,r,s} as one bit string, normalize it,
    // then round the top 24 bits to nearest-even.
    function automatic logic [34:0] model(input logic sgn, input logic [7:0] e_in,
                                          input logic [22:0] f, input logic [23:0] q,
                                          input logic g, input logic r, input logic s);
        logic [26:0] bits;
        logic [24:0] keep;
        logic        gd, st;
        int          e;
        if (e_in == 8'hFF && f != 0) return {32'h7FC00000, 3'b000};
        if (e_in == 8'hFF)           return {sgn, 31'h0, 3'b000};
        if (e_in == 8'h00)           return {sgn, 8'hFF, 23'h0, 3'b001};
        bits = {q, g, r, s};
        e    = 254 - int'(e_in);
        if (!bits[26]) begin
            bits = bits << 1;
            e    = e - 1;
        end
        keep = {1'b0, bits[26:3]};
        gd   = bits[2];
        st   = |bits[1:0];
        if (gd && (st || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = 25'h0800000;
            e    = e + 1;
        end
        if (e <= 0) return {sgn, 31'h0, 3'b110};
        return {sgn, 8'(e), keep[22:0], gd | st, 2'b00};
    endfunction

    // Monitor: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("sb_has_item", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0)
                    check("out", {29'h0, result, flag_inexact, flag_underflow, flag_divzero},
                          {29'h0, sb.pop_front()});
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                n_acc++;
            end
        end
    end

    task automatic set_in(input logic sgn, input logic [7:0] e, input logic [22:0] f,
                          input logic [23:0] q, input logic g, input logic r, input logic s,
                          input logic [34:0] x);
        sign_in = sgn; exp_in = e; frac_in = f; quotient = q;
        guard_bit = g; round_bit = r; sticky_bit = s;
        cur_exp = x;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic sgn, input logic [7:0] e, input logic [22:0] f,
                        input logic [23:0] q, input logic g, input logic r, input logic s,
                        input logic [34:0] x);
        logic done;
        done = 1'b0;
        set_in(sgn, e, f, q, g, r, s, x);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    // One-cycle accept, then out_valid must appear exactly two cycles after
    // the cycle in which the input was offered.
    task automatic latency_test(input string tag);
        set_in(1'b0, 8'd127, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b000});
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_c1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_c2"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int acc0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        set_in(1'b0, 8'd0, 23'h0, 24'h0, 1'b0, 1'b0, 1'b0, 35'h0);

        // Reset state
        #13;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags", 64'({flag_inexact, flag_underflow, flag_divzero}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First item after reset: 1/1.0, plus latency
        latency_test("lat0");

        // Rounding, exponent and underflow boundaries
        send(1'b0, 8'd127, 23'h0, 24'h555555, 1'b0, 1'b1, 1'b1, {32'h3F2AAAAB, 3'b100});
        send(1'b0, 8'd128, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h3F000000, 3'b000});
        send(1'b0, 8'd254, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b110});
        send(1'b0, 8'd253, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h00800000, 3'b000});
        // Round-up carry out of case B: mantissa 0xFFFFFF + 1 -> 1.0, E+1
        send(1'b0, 8'd127, 23'h0, 24'h7FFFFF, 1'b1, 1'b1, 1'b0, {32'h3F800000, 3'b100});
        // Tie, even LSB: no increment
        send(1'b0, 8'd127, 23'h0, 24'h800000, 1'b1, 1'b0, 1'b0, {32'h3F800000, 3'b100});

        // Special operands
        send(1'b1, 8'd0,   23'h0, 24'h555555, 1'b1, 1'b1, 1'b1, {32'hFF800000, 3'b001});
        send(1'b1, 8'd255, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h80000000, 3'b000});
        send(1'b0, 8'd255, 23'h1, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h7FC00000, 3'b000});
        drain("drain_basic");

        // Back-pressure: four offered, two accepted, output held stable
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send(1'b0, 8'd127, 23'h0, 24'h555555, 1'b0, 1'b1, 1'b1, {32'h3F2AAAAB, 3'b100});
                send(1'b0, 8'd128, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h3F000000, 3'b000});
                send(1'b0, 8'd254, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b110});
                send(1'b0, 8'd253, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h00800000, 3'b000});
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_hold_c3", 64'(result), 64'h3F2AAAAB);
                @(negedge clk);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_accepted", 64'(n_acc - acc0), 64'd2);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_hold_c4", 64'(result), 64'h3F2AAAAB);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with both stages full discards everything in flight
        out_ready = 1'b0;
        send(1'b0, 8'd127, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b000});
        send(1'b0, 8'd128, 23'h0, 24'h800000, 1'b0, 1'b0, 1'b0, {32'h3F000000, 3'b000});
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        latency_test("lat1");

        // Random traffic with random back-pressure
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    logic        sg, g, r, s;
                    logic [7:0]  e;
                    logic [22:0] f;
                    logic [23:0] q;
                    sg = 1'($urandom);
                    case ($urandom_range(0, 9))
                        0:       e = 8'd0;
                        1:       e = 8'd255;
                        2:       e = 8'($urandom_range(250, 254));
                        default: e = 8'($urandom_range(1, 254));
                    endcase
                    f = ($urandom_range(0, 1) != 0) ? 23'h0 : 23'($urandom);
                    q = ($urandom_range(0, 7) == 0) ? 24'h800000 : {2'b01, 22'($urandom)};
                    if ($urandom_range(0, 7) == 0) q = 24'h7FFFFF;
                    g = 1'($urandom); r = 1'($urandom); s = 1'($urandom);
                    send(sg, e, f, q, g, r, s, model(sg, e, f, q, g, r, s));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("drain_rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
